// File: rtl/edge_pkg.sv
// Shared edge-mode encodings and elaboration helpers for the multi-channel edge detector.
package edge_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Ceiling log2, used to size the debounce counter at elaboration time.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/edge_ch.sv
// One conditioned input channel: synchroniser, debounce filter, edge select,
// one-cycle tick, sticky pending flag and saturating event counter.
module edge_ch
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8,
    parameter bit RESET_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic [1:0]       edge_sel,
    input  logic             clr,
    output logic             level,
    output logic             tick,
    output logic             pend,
    output logic [CNT_W-1:0] cnt
);

    localparam int                DB_W    = (DB_CYCLES > 1) ? clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DB_W-1:0]        db_cnt;
    logic                   accept;
    logic                   tick_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != level) && (db_cnt == DB_LAST);

    // The mode is judged against the level being accepted, i.e. the new value s.
    always_comb begin
        tick_en = 1'b0;
        case (edge_sel)
            EDGE_OFF:  tick_en = 1'b0;
            EDGE_RISE: tick_en = s;
            EDGE_FALL: tick_en = ~s;
            EDGE_BOTH: tick_en = 1'b1;
            default:   tick_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    // Any sample equal to the current level restarts the qualification window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level  <= RESET_LEVEL;
            db_cnt <= '0;
        end else if (s == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= accept & tick_en;
        end
    end

    // A tick coinciding with clr wins: the flag stays set and the count restarts at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            cnt  <= '0;
        end else if (tick) begin
            pend <= 1'b1;
            cnt  <= clr ? CNT_W'(1) : sat_inc(cnt);
        end else if (clr) begin
            pend <= 1'b0;
            cnt  <= '0;
        end
    end

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel input conditioner: CH independent edge_ch channels plus a
// registered interrupt that reports any pending channel.
module multi_edge_detect
    import edge_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int CNT_W       = 8,
    parameter bit RESET_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       d,
    input  logic [2*CH-1:0]     edge_sel,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       level,
    output logic [CH-1:0]       tick,
    output logic [CH-1:0]       pend,
    output logic [CH*CNT_W-1:0] cnt,
    output logic                irq
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .CNT_W       (CNT_W),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .d        (d[i]),
            .edge_sel (edge_sel[2*i +: 2]),
            .clr      (clr[i]),
            .level    (level[i]),
            .tick     (tick[i]),
            .pend     (pend[i]),
            .cnt      (cnt[CNT_W*i +: CNT_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |pend;
        end
    end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench for multi_edge_detect: a window-based reference model predicts
// every cycle's outputs, and a monitor compares them after each rising edge.
module tb_multi_edge_detect;

    localparam int CH      = 4;
    localparam int SYNC    = 2;
    localparam int DB      = 4;
    localparam int CNT_W   = 8;
    localparam bit RL      = 1'b1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       d;
    logic [2*CH-1:0]     edge_sel;
    logic [CH-1:0]       clr;
    logic [CH-1:0]       level;
    logic [CH-1:0]       tick;
    logic [CH-1:0]       pend;
    logic [CH*CNT_W-1:0] cnt;
    logic                irq;

    multi_edge_detect #(
        .CH          (CH),
        .SYNC_STAGES (SYNC),
        .DB_CYCLES   (DB),
        .CNT_W       (CNT_W),
        .RESET_LEVEL (RL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .edge_sel (edge_sel),
        .clr      (clr),
        .level    (level),
        .tick     (tick),
        .pend     (pend),
        .cnt      (cnt),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0]       level;
        logic [CH-1:0]       tick;
        logic [CH-1:0]       pend;
        logic [CH*CNT_W-1:0] cnt;
        logic                irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: outputs as visible after the most recent rising edge.
    logic [CH-1:0] m_level;
    logic [CH-1:0] m_tick;
    logic [CH-1:0] m_pend;
    int            m_cnt[CH];
    logic          m_irq;
    logic [CH-1:0] hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_level = {CH{RL}};
        m_tick  = '0;
        m_pend  = '0;
        m_irq   = 1'b0;
        for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        hist.delete();
        repeat (SYNC + DB) hist.push_back({CH{RL}});
    endtask

    // A level change is accepted once the DB most recent synchronised samples
    // (raw samples SYNC..SYNC+DB-1 edges old) all differ from the current level.
    task automatic model_step();
        logic [CH-1:0] new_level, new_tick, new_pend, smp;
        logic          all_diff;
        logic [1:0]    mode;
        int            last;
        hist.push_back(d);
        if (hist.size() > SYNC + DB + 1) void'(hist.pop_front());
        last      = hist.size() - 1;
        new_level = m_level;
        new_tick  = '0;
        for (int c = 0; c < CH; c++) begin
            all_diff = 1'b1;
            for (int j = SYNC; j < SYNC + DB; j++) begin
                smp = hist[last - j];
                if (smp[c] == m_level[c]) all_diff = 1'b0;
            end
            if (all_diff) begin
                new_level[c] = ~m_level[c];
                mode = edge_sel[2*c +: 2];
                new_tick[c] = (mode == 2'b11) || (mode == 2'b01 && new_level[c]) ||
                              (mode == 2'b10 && !new_level[c]);
            end
        end
        for (int c = 0; c < CH; c++) begin
            new_pend[c] = m_tick[c] | (m_pend[c] & ~clr[c]);
            if (m_tick[c]) m_cnt[c] = clr[c] ? 1 : ((m_cnt[c] < CNT_MAX) ? m_cnt[c] + 1 : CNT_MAX);
            else if (clr[c]) m_cnt[c] = 0;
        end
        m_irq   = |m_pend;
        m_pend  = new_pend;
        m_tick  = new_tick;
        m_level = new_level;
    endtask

    // Predict the outputs for the coming rising edge, queue them, advance one cycle.
    task automatic cycle();
        exp_t e;
        if (rst) model_reset();
        else model_step();
        e.level = m_level;
        e.tick  = m_tick;
        e.pend  = m_pend;
        e.irq   = m_irq;
        for (int c = 0; c < CH; c++) e.cnt[CNT_W*c +: CNT_W] = CNT_W'(m_cnt[c]);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("sb_level", 32'(level), 32'(mon_e.level));
                chk("sb_tick",  32'(tick),  32'(mon_e.tick));
                chk("sb_pend",  32'(pend),  32'(mon_e.pend));
                chk("sb_cnt",   32'(cnt),   32'(mon_e.cnt));
                chk("sb_irq",   32'(irq),   32'(mon_e.irq));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  ticks;
        bit  found;
        rst      = 1'b0;
        d        = {CH{1'b1}};
        edge_sel = '0;
        clr      = '0;
        #1 rst   = 1'b1;
        model_reset();

        // Reset with idle-high inputs, then a quiet hold.
        repeat (3) cycle();
        rst = 1'b0;
        repeat (20) cycle();
        chk("t1_level", 32'(level), 32'hF);
        chk("t1_cnt",   32'(cnt),   32'h0);
        chk("t1_pend",  32'(pend),  32'h0);
        chk("t1_irq",   32'(irq),   32'h0);

        // Falling edge on ch0: tick appears after the sixth edge.
        edge_sel = 8'b00_11_11_10;
        d[0] = 1'b0;
        repeat (5) cycle();
        chk("t2_tick_early", 32'(tick[0]), 32'h0);
        cycle();
        chk("t2_tick",  32'(tick[0]),  32'h1);
        chk("t2_level", 32'(level[0]), 32'h0);
        cycle();
        chk("t2_pend",  32'(pend[0]),  32'h1);
        chk("t2_cnt",   32'(cnt[7:0]), 32'h1);
        chk("t2_irq_lag", 32'(irq),    32'h0);
        cycle();
        chk("t2_irq",   32'(irq),      32'h1);

        // Three-cycle glitch on ch1 is rejected.
        d[1] = 1'b0;
        repeat (3) cycle();
        d[1] = 1'b1;
        repeat (10) cycle();
        chk("t3_level", 32'(level[1]),  32'h1);
        chk("t3_cnt",   32'(cnt[15:8]), 32'h0);

        // Three toggles on ch2 (both) and ch3 (off).
        ticks = 0;
        for (int t = 0; t < 3; t++) begin
            d[2] = ~d[2];
            d[3] = ~d[3];
            repeat (10) begin
                cycle();
                if (tick[2]) ticks++;
            end
        end
        chk("t4_ticks",  32'(ticks),      32'h3);
        chk("t4_cnt2",   32'(cnt[23:16]), 32'h3);
        chk("t4_cnt3",   32'(cnt[31:24]), 32'h0);
        chk("t4_level3", 32'(level[3]),   32'h0);

        // clr coinciding with a tick on ch0, then saturation.
        d[0] = 1'b1;
        repeat (10) cycle();
        d[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (m_tick[0]) found = 1'b1;
        end
        chk("t5_tick_seen", 32'(found), 32'h1);
        clr[0] = 1'b1;
        cycle();
        clr[0] = 1'b0;
        chk("t5_pend", 32'(pend[0]),  32'h1);
        chk("t5_cnt",  32'(cnt[7:0]), 32'h1);
        repeat (300) begin
            d[0] = 1'b1;
            repeat (7) cycle();
            d[0] = 1'b0;
            repeat (7) cycle();
        end
        repeat (2) cycle();
        chk("t5_sat", 32'(cnt[7:0]), 32'hFF);

        // Reset in the middle of a debounce on ch1.
        d[1] = 1'b0;
        repeat (4) cycle();
        rst = 1'b1;
        d   = {CH{1'b1}};
        repeat (2) cycle();
        rst = 1'b0;
        ticks = 0;
        repeat (10) begin
            cycle();
            if (tick[1]) ticks++;
        end
        chk("t6_ticks", 32'(ticks),    32'h0);
        chk("t6_level", 32'(level[1]), 32'h1);
        chk("t6_pend",  32'(pend),     32'h0);
        chk("t6_cnt",   32'(cnt),      32'h0);

        // Randomised traffic across all channels.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) d[c] = ~d[c];
                clr[c] = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 49) == 0) edge_sel = 8'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 1'b0;
        clr = '0;
        repeat (2) cycle();
        chk("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
